// File: rtl/global_buffer_param.sv
// Global buffer sizing defaults shared by the GLB core blocks.
package global_buffer_param;

   localparam int PC_SCHED_DEPTH     = 4;
   localparam int PC_SCHED_GAP_WIDTH = 8;

endpackage

// File: rtl/global_buffer_pkg.sv
// Global buffer types: the parallel-config DMA header and the PC scheduler states.
package global_buffer_pkg;

   typedef struct packed {
      logic [15:0] startAddr;
      logic [15:0] numWords;
   } dma_pc_header_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_DONE = 3'd2,
      GAP       = 3'd3,
      DONE      = 3'd4
   } pc_sched_state_e;

endpackage

// File: rtl/glb_core_pc_sched.sv
// Parallel-config scheduler: walks a queue of DMA headers, issuing one PC DMA
// segment at a time with an optional idle gap between segments.
module glb_core_pc_sched
   import global_buffer_pkg::*;
#(
   parameter int PC_SCHED_DEPTH     = global_buffer_param::PC_SCHED_DEPTH,
   parameter int PC_SCHED_GAP_WIDTH = global_buffer_param::PC_SCHED_GAP_WIDTH
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              cfg_pc_sched_en,
   input  logic [$clog2(PC_SCHED_DEPTH):0]   cfg_pc_num_headers,
   input  dma_pc_header_t                    cfg_pc_header_arr [PC_SCHED_DEPTH],
   input  logic [PC_SCHED_GAP_WIDTH-1:0]     cfg_pc_gap,
   input  logic                              pc_sched_start_pulse,
   output logic                              pc_sched_done_pulse,
   output logic                              cfg_pc_dma_mode,
   output dma_pc_header_t                    cfg_pc_dma_header,
   output logic                              pc_start_pulse,
   input  logic                              pc_done_pulse,
   output logic                              pc_sched_busy,
   output logic [$clog2(PC_SCHED_DEPTH)-1:0] pc_sched_cur_idx
);

   localparam int IDX_W = $clog2(PC_SCHED_DEPTH);
   localparam int CNT_W = IDX_W + 1;
   localparam int GW    = PC_SCHED_GAP_WIDTH;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PC_SCHED_DEPTH);

   pc_sched_state_e  r_state;
   pc_sched_state_e  w_stateNext;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idxNext;
   logic [GW-1:0]    r_gapCnt;
   logic [GW-1:0]    w_gapCntNext;
   logic             r_pcDoneD;
   logic             w_doneRise;
   logic [CNT_W-1:0] w_count;
   logic             w_lastSeg;

   // A DMA done pulse may stay high for several cycles; only its leading edge counts.
   assign w_doneRise = pc_done_pulse & ~r_pcDoneD;
   assign w_count    = (cfg_pc_num_headers > DEPTH_C) ? DEPTH_C : cfg_pc_num_headers;
   assign w_lastSeg  = ({1'b0, r_idx} == (w_count - CNT_W'(1)));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_gapCnt  <= '0;
         r_pcDoneD <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_idx     <= w_idxNext;
         r_gapCnt  <= w_gapCntNext;
         r_pcDoneD <= pc_done_pulse;
      end
   end

   // Dropping the enable abandons the sequence silently from any active state.
   always_comb begin
      w_stateNext  = r_state;
      w_idxNext    = r_idx;
      w_gapCntNext = r_gapCnt;
      if ((r_state != IDLE) && !cfg_pc_sched_en) begin
         w_stateNext  = IDLE;
         w_idxNext    = '0;
         w_gapCntNext = '0;
      end else begin
         case (r_state)
            IDLE: begin
               w_idxNext = '0;
               if (pc_sched_start_pulse && cfg_pc_sched_en) begin
                  w_stateNext = (cfg_pc_num_headers == '0) ? DONE : ISSUE;
               end
            end
            ISSUE: w_stateNext = WAIT_DONE;
            WAIT_DONE: begin
               if (w_doneRise) begin
                  if (w_lastSeg) begin
                     w_stateNext = DONE;
                  end else if (cfg_pc_gap == '0) begin
                     w_stateNext = ISSUE;
                     w_idxNext   = r_idx + IDX_W'(1);
                  end else begin
                     w_stateNext  = GAP;
                     w_gapCntNext = cfg_pc_gap;
                  end
               end
            end
            GAP: begin
               if (r_gapCnt <= GW'(1)) begin
                  w_stateNext  = ISSUE;
                  w_idxNext    = r_idx + IDX_W'(1);
                  w_gapCntNext = '0;
               end else begin
                  w_gapCntNext = r_gapCnt - GW'(1);
               end
            end
            DONE: begin
               w_stateNext = IDLE;
               w_idxNext   = '0;
            end
            default: begin
               w_stateNext = IDLE;
               w_idxNext   = '0;
            end
         endcase
      end
   end

   assign pc_start_pulse      = (r_state == ISSUE);
   assign pc_sched_done_pulse = (r_state == DONE);
   assign pc_sched_busy       = (r_state != IDLE);
   assign cfg_pc_dma_mode     = (r_state != IDLE);
   assign cfg_pc_dma_header   = (r_state != IDLE) ? cfg_pc_header_arr[r_idx] : '0;
   assign pc_sched_cur_idx    = r_idx;

endmodule

// File: tb/tb_glb_core_pc_sched.sv
// Self-checking bench for glb_core_pc_sched: directed scenarios plus randomized runs
// against an event-timing reference model and a simple PC DMA responder.
module tb_glb_core_pc_sched;
   import global_buffer_pkg::*;

   localparam int DEPTH = 4;
   localparam int GW    = 8;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic           cfgEn;
   logic [2:0]     cfgNum;
   dma_pc_header_t hdrArr [DEPTH];
   logic [GW-1:0]  cfgGap;
   logic           startPulse;
   logic           schedDone;
   logic           dmaMode;
   dma_pc_header_t dmaHeader;
   logic           dmaStart;
   logic           dmaDone;
   logic           busy;
   logic [1:0]     curIdx;

   always #5 clock = ~clock;

   glb_core_pc_sched #(.PC_SCHED_DEPTH(DEPTH), .PC_SCHED_GAP_WIDTH(GW)) dut (
      .clk(clock), .reset(reset), .cfg_pc_sched_en(cfgEn), .cfg_pc_num_headers(cfgNum),
      .cfg_pc_header_arr(hdrArr), .cfg_pc_gap(cfgGap), .pc_sched_start_pulse(startPulse),
      .pc_sched_done_pulse(schedDone), .cfg_pc_dma_mode(dmaMode), .cfg_pc_dma_header(dmaHeader),
      .pc_start_pulse(dmaStart), .pc_done_pulse(dmaDone), .pc_sched_busy(busy),
      .pc_sched_cur_idx(curIdx));

   int errCount = 0;
   int checkCount = 0;
   int cyc = 0;

   // Reference model: the next scheduled event (1 = segment start, 2 = completion) and its cycle
   int pendKind, pendCycle, pendIdx;
   bit mBusy, mClearNext, mWaiting, prevPulse;
   int mWaitFrom, mIdx, mCount;

   bit goStart, goEn;
   int dmaDelay, dmaWidth, dmaCountdown, dmaHighLeft;

   int obsStarts, obsDones, lastDoneCyc, lastStartDriveCyc;
   int startCycles[$];
   int startIdxs[$];
   int riseCycles[$];

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic modelReset();
      pendKind = 0; pendCycle = 0; pendIdx = 0;
      mBusy = 0; mClearNext = 0; mWaiting = 0; prevPulse = 0;
      mWaitFrom = 0; mIdx = 0; mCount = 0;
      dmaCountdown = -1; dmaHighLeft = 0;
   endtask

   task automatic applyReset();
      reset = 1'b1;
      #1;
      checkOutput("rst_start_pulse", dmaStart, 0);
      checkOutput("rst_done_pulse", schedDone, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_dma_mode", dmaMode, 0);
      checkOutput("rst_dma_header", dmaHeader, 0);
      checkOutput("rst_cur_idx", curIdx, 0);
      @(posedge clock);
      @(negedge clock);
      checkOutput("rst_busy_held", busy, 0);
      startPulse = 1'b0;
      dmaDone = 1'b0;
      modelReset();
      reset = 1'b0;
   endtask

   // One clock: check outputs against the model, then drive the next inputs and let the model react.
   task automatic stepCycle();
      bit expStart, expDone, rise;
      logic [31:0] expHdr;
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (mClearNext) begin
         mBusy = 0; mIdx = 0; mClearNext = 0;
      end
      expStart = (pendKind == 1) && (pendCycle == cyc);
      expDone  = (pendKind == 2) && (pendCycle == cyc);
      if (expStart) begin
         mBusy = 1; mIdx = pendIdx; pendKind = 0; mWaiting = 1; mWaitFrom = cyc + 1;
      end
      if (expDone) begin
         mBusy = 1; pendKind = 0; mClearNext = 1;
      end
      if (mBusy) expHdr = hdrArr[mIdx];
      else       expHdr = 32'h0;
      checkOutput("start_pulse", dmaStart, expStart);
      checkOutput("done_pulse", schedDone, expDone);
      checkOutput("busy", busy, mBusy);
      checkOutput("dma_mode", dmaMode, mBusy);
      checkOutput("dma_header", dmaHeader, expHdr);
      checkOutput("cur_idx", curIdx, mIdx);

      if (dmaStart) begin
         obsStarts++;
         startCycles.push_back(cyc);
         startIdxs.push_back(int'(curIdx));
         dmaCountdown = dmaDelay;
      end
      if (schedDone) begin
         obsDones++;
         lastDoneCyc = cyc;
      end

      startPulse = goStart;
      if (goStart) lastStartDriveCyc = cyc;
      goStart = 0;
      cfgEn = goEn;
      dmaDone = 1'b0;
      if (dmaHighLeft > 0) begin
         dmaDone = 1'b1;
         dmaHighLeft--;
      end
      if (dmaCountdown == 0) begin
         dmaDone = 1'b1;
         dmaHighLeft = dmaWidth - 1;
         dmaCountdown = -1;
      end else if (dmaCountdown > 0) begin
         dmaCountdown--;
      end

      rise = dmaDone && !prevPulse;
      prevPulse = dmaDone;
      if (rise) riseCycles.push_back(cyc);
      if (mBusy && !cfgEn) begin
         pendKind = 0; mWaiting = 0; mClearNext = 1;
      end else if (!mBusy && pendKind == 0) begin
         if (startPulse && cfgEn) begin
            mCount = (int'(cfgNum) > DEPTH) ? DEPTH : int'(cfgNum);
            pendKind = (mCount == 0) ? 2 : 1;
            pendCycle = cyc + 1;
            pendIdx = 0;
         end
      end else if (mWaiting && cyc >= mWaitFrom && rise) begin
         mWaiting = 0;
         if (mIdx == mCount - 1) begin
            pendKind = 2; pendCycle = cyc + 1;
         end else begin
            pendKind = 1; pendCycle = cyc + 1 + int'(cfgGap); pendIdx = mIdx + 1;
         end
      end
   endtask

   task automatic runUntilIdle(input int budget, input int extraStartAt, input int enDropAt,
                               input int minCycles);
      int k = 0;
      while (k < budget && (k < minCycles || mBusy || pendKind != 0 ||
                            dmaCountdown >= 0 || dmaHighLeft > 0)) begin
         if (k == extraStartAt) goStart = 1;
         if (k == enDropAt) goEn = 0;
         stepCycle();
         k++;
      end
      checkOutput("run_budget_exceeded", (k >= budget), 0);
      checkOutput("idle_after_run", busy, 0);
   endtask

   task automatic applyStimulus(input int num, input int gap, input int delay, input int width,
                                input int extraStartAt, input int enDropAt);
      cfgNum = 3'(num);
      cfgGap = GW'(gap);
      dmaDelay = delay;
      dmaWidth = width;
      for (int i = 0; i < DEPTH; i++) hdrArr[i] = $urandom;
      obsStarts = 0; obsDones = 0; lastDoneCyc = -1; lastStartDriveCyc = -1;
      startCycles.delete(); startIdxs.delete(); riseCycles.delete();
      goEn = 1; goStart = 1;
      runUntilIdle(400, extraStartAt, enDropAt, 4);
      goEn = 1;
   endtask

   int extraAt, dropAt;

   initial begin
      cfgEn = 1'b0; cfgNum = '0; cfgGap = '0; startPulse = 1'b0; dmaDone = 1'b0;
      for (int i = 0; i < DEPTH; i++) hdrArr[i] = '0;
      goStart = 0; goEn = 0; dmaDelay = 10; dmaWidth = 1;
      modelReset();
      #2;
      applyReset();

      $display("[TB] three headers, no gap, 4-cycle DMA done");
      applyStimulus(3, 0, 10, 4, -1, -1);
      checkOutput("t1_segments", obsStarts, 3);
      checkOutput("t1_done_count", obsDones, 1);
      checkOutput("t1_done_latency",
                  lastDoneCyc - ((riseCycles.size() >= 3) ? riseCycles[2] : -100), 1);
      checkOutput("t1_third_idx", (startIdxs.size() >= 3) ? startIdxs[2] : -1, 2);

      $display("[TB] two headers, gap of 5");
      applyStimulus(2, 5, 10, 3, -1, -1);
      checkOutput("t2_gap_latency",
                  ((startCycles.size() >= 2) ? startCycles[1] : -100) -
                  ((riseCycles.size() >= 1) ? riseCycles[0] : 0), 6);

      $display("[TB] zero headers");
      applyStimulus(0, 3, 10, 1, -1, -1);
      checkOutput("t3_no_segments", obsStarts, 0);
      checkOutput("t3_done_count", obsDones, 1);
      checkOutput("t3_done_latency", lastDoneCyc - lastStartDriveCyc, 1);

      $display("[TB] clamp of seven headers, restart while busy");
      applyStimulus(7, 1, 6, 2, 8, -1);
      checkOutput("t4_segments", obsStarts, 4);
      checkOutput("t4_done_count", obsDones, 1);
      checkOutput("t4_last_idx", (startIdxs.size() >= 4) ? startIdxs[3] : -1, 3);

      $display("[TB] enable dropped while waiting for DMA");
      applyStimulus(3, 0, 10, 4, -1, 5);
      checkOutput("t5_segments", obsStarts, 1);
      checkOutput("t5_no_done", obsDones, 0);
      checkOutput("t5_late_rise_seen", riseCycles.size(), 1);

      $display("[TB] reset during gap");
      cfgNum = 3'd3; cfgGap = GW'(20); dmaDelay = 6; dmaWidth = 1;
      goEn = 1; goStart = 1;
      for (int k = 0; k < 200; k++) begin
         stepCycle();
         if (pendKind == 1 && pendCycle > cyc + 5) break;
      end
      checkOutput("t6_in_gap_busy", busy, 1);
      applyReset();
      applyStimulus(2, 0, 7, 2, -1, -1);
      checkOutput("t6_first_idx", (startIdxs.size() >= 1) ? startIdxs[0] : -1, 0);
      checkOutput("t6_segments", obsStarts, 2);

      $display("[TB] randomized runs");
      for (int r = 0; r < 10; r++) begin
         extraAt = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 30)) : -1;
         dropAt  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 40)) : -1;
         applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 6)),
                       int'($urandom_range(5, 12)), int'($urandom_range(1, 4)), extraAt, dropAt);
         runUntilIdle(100, -1, -1, 3);
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
